cache_probe_sequencer: RTL and testbench
========================================

Name: cache_probe_sequencer

Overview:
- Hardware access sequencer that sits directly upstream of cacheSystem and drives its addr/enable request port.
- On a start pulse it walks a strided address sequence of programmable length and issues one read per address.
- For every read it counts the cycles until requestComplete and reports that latency together with the returned data.
- It keeps running min/max/sum latency statistics, so cache delays and geometry can be characterised by sweeping base/stride/count from a bench or controller.

Parameters:
ADDR_W, 15, width of cache address
DATA_W, 32, width of cache read data
CNT_W, 10, width of access-count field (max 1023 accesses per run)
LAT_W, 14, width of per-access latency counter
TIMEOUT, 10000, latency at which an access is abandoned and flagged

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
abort  in  1  level; terminates the current run
base_addr  in  ADDR_W  first address of run, latched on start
stride  in  ADDR_W  address increment, latched on start
count  in  CNT_W  number of accesses, latched on start
cache_addr  out  ADDR_W  address to cacheSystem
cache_enable  out  1  request to cacheSystem
cache_requestComplete  in  1  completion from cacheSystem
cache_dataOut  in  DATA_W  read data from cacheSystem
busy  out  1  high in every state except IDLE
res_valid  out  1  one-cycle pulse per finished access
res_addr  out  ADDR_W  address of reported access
res_latency  out  LAT_W  latency of reported access
res_data  out  DATA_W  data of reported access
res_timeout  out  1  reported access timed out (qualifies res_valid)
done  out  1  one-cycle pulse at end of run
stat_min  out  LAT_W  minimum latency of run
stat_max  out  LAT_W  maximum latency of run
stat_sum  out  LAT_W+CNT_W  sum of latencies of run
error  out  1  sticky; set on any timeout or abort, cleared by next start

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0, except stat_min = all-ones.
- FSM states: IDLE, ACCESS, GAP, DONE. All outputs are registered or decoded from the state register only.
- IDLE:
  - start=1: latch base/stride/count; cur_addr=base; remaining=count; lat=0; clear stats (min all-ones, max 0, sum 0) and error.
  - If count==0, go to DONE; otherwise go to ACCESS.
- ACCESS:
  - cache_enable=1 and cache_addr=cur_addr, held stable for the whole state.
  - Each edge with requestComplete=0: lat++.
  - Edge with requestComplete=1: res_valid=1 next cycle, with res_latency=lat, res_data=cache_dataOut, res_addr=cur_addr.
  - On that completion, update stats: min/max compare and sum+=lat, with sum saturating at all-ones. Then go to GAP.
  - Latency definition: lat is the number of enabled cycles before the completion edge. A cache that answers on its first enabled edge reports 0.
  - lat reaching TIMEOUT: res_valid=1 with res_timeout=1 and res_latency=TIMEOUT. Set error; stats are NOT updated; go to GAP.
- GAP:
  - Exactly one cycle with cache_enable=0 (request-separation rule of cacheSystem).
  - remaining--; cur_addr += stride, modulo 2^ADDR_W (wraps silently); lat=0.
  - remaining==0 after the decrement: go to DONE; otherwise go to ACCESS.
- DONE: done=1 for one cycle, stats stable; go to IDLE. Stats hold until the next accepted start.
- abort=1 in ACCESS or GAP:
  - Next state is DONE, cache_enable drops on the following cycle, error is set.
  - No res_valid is produced for the interrupted access, even if requestComplete coincides with abort; abort wins.
- Other boundary rules:
  - start while busy is ignored.
  - start and abort together in IDLE: start is accepted and abort is ignored.
  - requestComplete outside ACCESS is ignored.
  - Reset asserted mid-run: immediate return to IDLE, enable=0, no done pulse.

Decomposition:
- Package cache_probe_pkg holds:
  - state enum probe_state_t {IDLE, ACCESS, GAP, DONE};
  - default widths;
  - TIMEOUT constant;
  - LAT_ALL_ONES.
- One natural sub-module, probe_latency_stats: takes lat, update and clear, and produces min/max/saturating sum.

Test Plan:
- Mock cache with fixed 3-cycle latency; start with base=0, stride=4, count=4 -> four res_valid pulses at addresses 0, 4, 8, 12, each with latency 3; stat_min=3, stat_max=3, stat_sum=12; done once; enable low exactly 1 cycle between accesses.
- Mock with latency 0 for the first access and 20 for the rest, count=3 -> latencies 0, 20, 20; min=0, max=20, sum=40.
- Mock that never completes, count=2 -> two res_valid pulses with res_timeout=1 and latency 10000; error=1; stats remain min=all-ones, max=0, sum=0.
- base=0x7FFC, stride=8, count=2 -> second access at address 0x0004 (wrap).
- Assert abort during the second access of count=5, with requestComplete on the same cycle -> no res_valid for that access; done next cycle; error=1; busy falls.
- Pulse reset low mid-ACCESS -> cache_enable=0 and all outputs cleared asynchronously; a later start with count=0 -> done pulse, no res_valid.

Source files
------------

// File: rtl/cache_probe_pkg.sv
// Shared types and default geometry for the cache probe sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_probe_pkg;

  localparam int ADDR_W_DEF    = 15;
  localparam int DATA_W_DEF    = 32;
  localparam int CNT_W_DEF     = 10;
  localparam int LAT_W_DEF     = 14;
  localparam int PROBE_TIMEOUT = 10000;

  // Reset/clear value of the running minimum at the default latency width.
  localparam logic [LAT_W_DEF-1:0] LAT_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } probe_state_t;

endpackage

// File: rtl/probe_latency_stats.sv
// Running min/max/saturating-sum of per-access latencies for one probe run.
// Latency: results visible one cycle after update_i / clear_i.
// Backpressure: none; update_i is sampled every cycle, clear_i wins over update_i.
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i restarts the
//        statistics; update_i folds lat_i in; min_o/max_o/sum_o are registered.
module probe_latency_stats
  import cache_probe_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF,
  parameter int SUM_W = LAT_W_DEF + CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             update_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic [LAT_W-1:0] min_o,
  output logic [LAT_W-1:0] max_o,
  output logic [SUM_W-1:0] sum_o
);

  logic [LAT_W-1:0] min_q, min_d;
  logic [LAT_W-1:0] max_q, max_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0]   sum_ext;

  // One extra bit catches the carry so the sum can saturate instead of wrap.
  assign sum_ext = {1'b0, sum_q} + {{(SUM_W + 1 - LAT_W){1'b0}}, lat_i};

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    sum_d = sum_q;
    if (clear_i) begin
      min_d = '1;
      max_d = '0;
      sum_d = '0;
    end else if (update_i) begin
      if (lat_i < min_q) min_d = lat_i;
      if (lat_i > max_q) max_d = lat_i;
      sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/cache_probe_sequencer.sv
// Walks a strided address run into cacheSystem, timing each read and reporting per-access results plus stats.
// Latency: one result pulse the cycle after requestComplete (or timeout); one idle GAP cycle between requests.
// Backpressure: none downstream; upstream cache throttles via requestComplete, abort terminates the run.
// Ports: clock/reset (async active-low); start/abort control with base_addr/stride/count
//        latched on start; cache_* request port to cacheSystem; res_* per-access report;
//        busy/done/error run status; stat_min/stat_max/stat_sum latency statistics.
module cache_probe_sequencer
  import cache_probe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LAT_W   = LAT_W_DEF,
  parameter int TIMEOUT = PROBE_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      stride,
  input  logic [CNT_W-1:0]       count,
  output logic [ADDR_W-1:0]      cache_addr,
  output logic                   cache_enable,
  input  logic                   cache_requestComplete,
  input  logic [DATA_W-1:0]      cache_dataOut,
  output logic                   busy,
  output logic                   res_valid,
  output logic [ADDR_W-1:0]      res_addr,
  output logic [LAT_W-1:0]       res_latency,
  output logic [DATA_W-1:0]      res_data,
  output logic                   res_timeout,
  output logic                   done,
  output logic [LAT_W-1:0]       stat_min,
  output logic [LAT_W-1:0]       stat_max,
  output logic [LAT_W+CNT_W-1:0] stat_sum,
  output logic                   error
);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_TMO  = LAT_W'(TIMEOUT);

  probe_state_t      state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              res_valid_q, res_valid_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [LAT_W-1:0]  res_latency_q, res_latency_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_timeout_q, res_timeout_d;
  logic              error_q, error_d;
  logic              stat_clear;
  logic              stat_update;

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    stride_d      = stride_q;
    remaining_d   = remaining_q;
    lat_d         = lat_q;
    res_valid_d   = 1'b0;
    res_addr_d    = res_addr_q;
    res_latency_d = res_latency_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    error_d       = error_q;
    stat_clear    = 1'b0;
    stat_update   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here: a coincident start wins.
        if (start) begin
          cur_addr_d  = base_addr;
          stride_d    = stride;
          remaining_d = count;
          lat_d       = '0;
          error_d     = 1'b0;
          stat_clear  = 1'b1;
          state_d     = (count == '0) ? DONE : ACCESS;
        end
      end

      ACCESS: begin
        if (abort) begin
          // Abort beats a coincident completion: the access is dropped unreported.
          error_d = 1'b1;
          state_d = DONE;
        end else if (cache_requestComplete) begin
          res_valid_d   = 1'b1;
          res_addr_d    = cur_addr_q;
          res_latency_d = lat_q;
          res_data_d    = cache_dataOut;
          res_timeout_d = 1'b0;
          stat_update   = 1'b1;
          state_d       = GAP;
        end else if (lat_q == LAT_LAST) begin
          // This edge would make lat reach TIMEOUT: give up on the access.
          res_valid_d   = 1'b1;
          res_addr_d    = cur_addr_q;
          res_latency_d = LAT_TMO;
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          error_d       = 1'b1;
          state_d       = GAP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          remaining_d = remaining_q - 1'b1;
          cur_addr_d  = cur_addr_q + stride_q;
          lat_d       = '0;
          state_d     = (remaining_q == CNT_W'(1)) ? DONE : ACCESS;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      stride_q      <= '0;
      remaining_q   <= '0;
      lat_q         <= '0;
      res_valid_q   <= 1'b0;
      res_addr_q    <= '0;
      res_latency_q <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      stride_q      <= stride_d;
      remaining_q   <= remaining_d;
      lat_q         <= lat_d;
      res_valid_q   <= res_valid_d;
      res_addr_q    <= res_addr_d;
      res_latency_q <= res_latency_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      error_q       <= error_d;
    end
  end

  probe_latency_stats #(
    .LAT_W (LAT_W),
    .SUM_W (LAT_W + CNT_W)
  ) u_stats (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (stat_clear),
    .update_i (stat_update),
    .lat_i    (lat_q),
    .min_o    (stat_min),
    .max_o    (stat_max),
    .sum_o    (stat_sum)
  );

  // Request port decodes straight from the state register so it stays
  // glitch-free and drops the instant reset is asserted.
  assign cache_enable = (state_q == ACCESS);
  assign cache_addr   = cache_enable ? cur_addr_q : '0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

  assign res_valid    = res_valid_q;
  assign res_addr     = res_addr_q;
  assign res_latency  = res_latency_q;
  assign res_data     = res_data_q;
  assign res_timeout  = res_timeout_q;
  assign error        = error_q;

endmodule

// File: tb/tb_cache_probe_sequencer.sv
module tb_cache_probe_sequencer;
  import cache_probe_pkg::*;

  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int CW  = 10;
  localparam int LW  = 14;
  localparam int TMO = 10000;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic           abort;
  logic [AW-1:0]  base_addr;
  logic [AW-1:0]  stride;
  logic [CW-1:0]  count;
  logic [AW-1:0]  cache_addr;
  logic           cache_enable;
  logic           cache_requestComplete;
  logic [DW-1:0]  cache_dataOut;
  logic           busy;
  logic           res_valid;
  logic [AW-1:0]  res_addr;
  logic [LW-1:0]  res_latency;
  logic [DW-1:0]  res_data;
  logic           res_timeout;
  logic           done;
  logic [LW-1:0]  stat_min;
  logic [LW-1:0]  stat_max;
  logic [LW+CW-1:0] stat_sum;
  logic           error;

  always #5 clock = ~clock;

  cache_probe_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .LAT_W(LW), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .stride(stride), .count(count),
    .cache_addr(cache_addr), .cache_enable(cache_enable),
    .cache_requestComplete(cache_requestComplete), .cache_dataOut(cache_dataOut),
    .busy(busy), .res_valid(res_valid), .res_addr(res_addr),
    .res_latency(res_latency), .res_data(res_data), .res_timeout(res_timeout),
    .done(done), .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum),
    .error(error)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] lat;
    logic [DW-1:0] data;
    logic          tmo;
  } res_t;

  int compared   = 0;
  int mismatched = 0;
  int lats[$];   // mock cache latency per access; >= TMO means never answers

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {a, 2'b10, a} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input logic [AW-1:0] s,
                                            input int i);
    return AW'(int'(b) + i * int'(s));
  endfunction

  // One complete run: drives start, plays the mock cache, collects reports,
  // then checks them against expectations derived from the run parameters.
  task automatic run_probe(input logic [AW-1:0] b, input logic [AW-1:0] s, input int n,
                           input int abort_at, input int abort_lat,
                           input bit abort_with_start, input bit restart_mid,
                           input int budget, input string tag);
    res_t got[$];
    int   acc_idx = 0;
    int   en_cnt  = 0;
    int   gap     = 0;
    bit   en_at_edge;
    bit   seen_done = 0;
    int   nres;
    logic [LW-1:0]    e_min = LAT_ALL_ONES;
    logic [LW-1:0]    e_max = '0;
    longint           e_sum = 0;
    bit               e_err;

    for (int cyc = 0; cyc < budget && !seen_done; cyc++) begin
      @(negedge clock);
      en_at_edge = cache_enable;
      start = 1'b0;
      abort = 1'b0;
      if (cyc == 0) begin
        base_addr = b; stride = s; count = CW'(n);
        start = 1'b1; abort = abort_with_start;
      end else if (restart_mid && cyc == 5) begin
        base_addr = AW'($urandom); stride = AW'($urandom); count = CW'($urandom);
        start = 1'b1;
      end
      if (cache_enable) begin
        cache_dataOut = data_of(cache_addr);
        cache_requestComplete = (acc_idx < lats.size()) && (en_cnt == lats[acc_idx]);
        if (acc_idx == abort_at && en_cnt == abort_lat) begin
          abort = 1'b1;
          cache_requestComplete = 1'b1;
        end
      end else begin
        cache_dataOut = $urandom;
        cache_requestComplete = 1'($urandom);
      end
      @(posedge clock);
      #1;
      if (res_valid) got.push_back('{res_addr, res_latency, res_data, res_timeout});
      if (en_at_edge && !cache_enable) begin
        acc_idx++;
        en_cnt = 0;
      end else if (en_at_edge) begin
        en_cnt++;
      end
      if (cache_enable && !en_at_edge) begin
        chk({tag, "/req_addr"}, cache_addr, addr_of(b, s, acc_idx));
        if (acc_idx > 0) chk({tag, "/gap_cycles"}, gap, 1);
        gap = 0;
      end else if (!cache_enable && busy) begin
        gap++;
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, "/enable_at_done"}, cache_enable, 1'b0);
      end
    end
    chk({tag, "/done_seen"}, seen_done, 1'b1);

    @(negedge clock);
    start = 1'b0; abort = 1'b0; cache_requestComplete = 1'b0;
    @(posedge clock);
    #1;
    chk({tag, "/done_single"}, done, 1'b0);
    chk({tag, "/busy_after"}, busy, 1'b0);

    nres  = (abort_at >= 0) ? abort_at : n;
    e_err = (abort_at >= 0);
    chk({tag, "/res_count"}, got.size(), nres);
    for (int i = 0; i < nres; i++) begin
      if (lats[i] >= TMO) begin
        e_err = 1'b1;
      end else begin
        if (LW'(lats[i]) < e_min) e_min = LW'(lats[i]);
        if (LW'(lats[i]) > e_max) e_max = LW'(lats[i]);
        e_sum += lats[i];
      end
      if (i < got.size()) begin
        chk({tag, "/res_addr"}, got[i].addr, addr_of(b, s, i));
        chk({tag, "/res_tmo"}, got[i].tmo, lats[i] >= TMO);
        chk({tag, "/res_lat"}, got[i].lat, (lats[i] >= TMO) ? TMO : lats[i]);
        if (lats[i] < TMO) chk({tag, "/res_data"}, got[i].data, data_of(addr_of(b, s, i)));
      end
    end
    if (e_sum > 64'hFF_FFFF) e_sum = 64'hFF_FFFF;
    chk({tag, "/stat_min"}, stat_min, e_min);
    chk({tag, "/stat_max"}, stat_max, e_max);
    chk({tag, "/stat_sum"}, stat_sum, e_sum);
    chk({tag, "/error"}, error, e_err);
  endtask

  initial begin
    int n;
    logic [AW-1:0] rb, rs;

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; stride = '0; count = '0;
    cache_requestComplete = 1'b0; cache_dataOut = '0;
    #23;
    chk("rst/busy", busy, 1'b0);
    chk("rst/enable", cache_enable, 1'b0);
    chk("rst/addr", cache_addr, 0);
    chk("rst/res_valid", res_valid, 1'b0);
    chk("rst/done", done, 1'b0);
    chk("rst/error", error, 1'b0);
    chk("rst/stat_min", stat_min, LAT_ALL_ONES);
    chk("rst/stat_max", stat_max, 0);
    chk("rst/stat_sum", stat_sum, 0);
    @(negedge clock);
    reset = 1'b1;

    // Fixed latency 3, with a start pulse while busy that must be ignored.
    lats = '{3, 3, 3, 3};
    run_probe(15'h0000, 15'd4, 4, -1, 0, 1'b0, 1'b1, 200, "fix3");

    // Immediate answer then slow answers; abort coinciding with start is ignored.
    lats = '{0, 20, 20};
    run_probe(15'h0100, 15'd1, 3, -1, 0, 1'b1, 1'b0, 300, "lat0_20");

    // Cache never answers: both accesses time out.
    lats = '{20000, 20000};
    run_probe(15'h0200, 15'd2, 2, -1, 0, 1'b0, 1'b0, 21000, "timeout");

    // Address wrap.
    lats = '{1, 2};
    run_probe(15'h7FFC, 15'd8, 2, -1, 0, 1'b0, 1'b0, 100, "wrap");

    // Abort during the second access, coinciding with requestComplete.
    lats = '{2, 9, 2, 2, 2};
    run_probe(15'h0040, 15'd16, 5, 1, 4, 1'b0, 1'b0, 200, "abort");

    // Reset mid-ACCESS.
    @(negedge clock);
    base_addr = 15'h0123; stride = 15'd1; count = 10'd3; start = 1'b1;
    cache_requestComplete = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("midrst/enable_before", cache_enable, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst/enable", cache_enable, 1'b0);
    chk("midrst/busy", busy, 1'b0);
    chk("midrst/addr", cache_addr, 0);
    chk("midrst/res_valid", res_valid, 1'b0);
    chk("midrst/done", done, 1'b0);
    chk("midrst/stat_min", stat_min, LAT_ALL_ONES);
    @(negedge clock);
    reset = 1'b1;

    // Zero-length run: done pulse only.
    lats = {};
    run_probe(15'h0055, 15'd3, 0, -1, 0, 1'b0, 1'b0, 20, "count0");

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(1, 6);
      rb = AW'($urandom);
      rs = AW'($urandom);
      lats = {};
      for (int i = 0; i < n; i++) lats.push_back($urandom_range(0, 8));
      run_probe(rb, rs, n, -1, 0, 1'($urandom), 1'($urandom), 300, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
